// File: rtl/dlx_pkg.sv
// Shared DLX definitions: operation kinds, decoder I-codes, and the
// opcode/function encodings that the encoder and decoder agree on.
// The helper functions return {valid, code}. Invalid means "no encoding".
package dlx_pkg;

  typedef enum logic [2:0] {
    R_ALU    = 3'd0,
    I_ALU    = 3'd1,
    LOAD     = 3'd2,
    STORE    = 3'd3,
    BRANCH   = 3'd4,
    JUMP     = 3'd5,
    JUMP_REG = 3'd6,
    LHI      = 3'd7
  } op_kind_t;

  // I-codes, exactly as the decoder emits them on I
  localparam logic [4:0] I_ADD  = 5'd1;
  localparam logic [4:0] I_SUB  = 5'd2;
  localparam logic [4:0] I_AND  = 5'd3;
  localparam logic [4:0] I_OR   = 5'd4;
  localparam logic [4:0] I_XOR  = 5'd5;
  localparam logic [4:0] I_SLL  = 5'd6;
  localparam logic [4:0] I_SRL  = 5'd7;
  localparam logic [4:0] I_SEQ  = 5'd10;
  localparam logic [4:0] I_SLE  = 5'd11;
  localparam logic [4:0] I_SLT  = 5'd12;
  localparam logic [4:0] I_SNE  = 5'd13;
  localparam logic [4:0] I_SRA  = 5'd14;
  localparam logic [4:0] I_BEQZ = 5'd16;
  localparam logic [4:0] I_BNEZ = 5'd17;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQZ    = 6'h04;
  localparam logic [5:0] OP_BNEZ    = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SUBI    = 6'h0a;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LHI     = 6'h0f;
  localparam logic [5:0] OP_JR      = 6'h12;
  localparam logic [5:0] OP_JALR    = 6'h13;
  localparam logic [5:0] OP_SLLI    = 6'h14;
  localparam logic [5:0] OP_SRLI    = 6'h16;
  localparam logic [5:0] OP_SRAI    = 6'h17;
  localparam logic [5:0] OP_SEQI    = 6'h18;
  localparam logic [5:0] OP_SNEI    = 6'h19;
  localparam logic [5:0] OP_SLTI    = 6'h1a;
  localparam logic [5:0] OP_SLEI    = 6'h1c;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_SRA = 6'h07;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SEQ = 6'h28;
  localparam logic [5:0] FN_SNE = 6'h29;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLE = 6'h2c;

  function automatic logic [6:0] r_alu_func(input logic [4:0] i);
    case (i)
      I_ADD:   return {1'b1, FN_ADD};
      I_SUB:   return {1'b1, FN_SUB};
      I_AND:   return {1'b1, FN_AND};
      I_OR:    return {1'b1, FN_OR};
      I_XOR:   return {1'b1, FN_XOR};
      I_SLL:   return {1'b1, FN_SLL};
      I_SRL:   return {1'b1, FN_SRL};
      I_SEQ:   return {1'b1, FN_SEQ};
      I_SLE:   return {1'b1, FN_SLE};
      I_SLT:   return {1'b1, FN_SLT};
      I_SNE:   return {1'b1, FN_SNE};
      I_SRA:   return {1'b1, FN_SRA};
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] i_alu_op(input logic [4:0] i);
    case (i)
      I_ADD:   return {1'b1, OP_ADDI};
      I_SUB:   return {1'b1, OP_SUBI};
      I_AND:   return {1'b1, OP_ANDI};
      I_OR:    return {1'b1, OP_ORI};
      I_XOR:   return {1'b1, OP_XORI};
      I_SLL:   return {1'b1, OP_SLLI};
      I_SRL:   return {1'b1, OP_SRLI};
      I_SEQ:   return {1'b1, OP_SEQI};
      I_SLE:   return {1'b1, OP_SLEI};
      I_SLT:   return {1'b1, OP_SLTI};
      I_SNE:   return {1'b1, OP_SNEI};
      I_SRA:   return {1'b1, OP_SRAI};
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] branch_op(input logic [4:0] i);
    case (i)
      I_BEQZ:  return {1'b1, OP_BEQZ};
      I_BNEZ:  return {1'b1, OP_BNEZ};
      default: return 7'd0;
    endcase
  endfunction

  // Arithmetic and compare immediates are sign-extended by the core;
  // logical and shift immediates are zero-extended.
  function automatic logic i_is_signed(input logic [4:0] i);
    return (i == I_ADD) || (i == I_SUB) || ((i >= I_SEQ) && (i <= I_SNE));
  endfunction

endpackage

// File: rtl/dlx_sync_fifo.sv
// Small synchronous FIFO used as the encoder output buffer.
// DEPTH must be a power of two so the pointers wrap for free.
module dlx_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers, occupancy and storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control flops; a reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dlx_encoder.sv
// DLX instruction encoder: packs decoded op fields into 32-bit words and
// streams them with sequential addresses to the instruction-memory loader.
// Optional macro DLX_ENC_RANGECHK_EN: reject immediates that do not fit
// their field (emitted as NOP with err set). Undefined: silent truncation.
module dlx_encoder
  import dlx_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  op_kind_t          in_kind,
  input  logic              in_link,
  input  logic [4:0]        in_i,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_iv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int FW = 32 + ADDR_W;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                done_q, done_d;

  logic [31:0]         raw_word;
  logic                code_ok;
  logic                range_ok;
  logic                enc_ok;
  logic [31:0]         enc_word;
  logic [6:0]          lut;

  logic                accept;
  logic                fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [FW-1:0]       fifo_rdata;

  assign in_ready  = (state_q == ST_RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 32'd0 : fifo_rdata[31:0];
  assign out_addr  = fifo_empty ? '0 : fifo_rdata[32 +: ADDR_W];
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

  // Field packing per op kind; unknown codes leave code_ok low
  always_comb begin
    raw_word = 32'd0;
    code_ok  = 1'b0;
    lut      = 7'd0;
    case (in_kind)
      R_ALU: begin
        lut      = r_alu_func(in_i);
        code_ok  = lut[6];
        raw_word = {OP_SPECIAL, in_rs1, in_rs2, in_rd, 5'd0, lut[5:0]};
      end
      I_ALU: begin
        lut      = i_alu_op(in_i);
        code_ok  = lut[6];
        raw_word = {lut[5:0], in_rs1, in_rd, in_iv[15:0]};
      end
      LOAD: begin
        code_ok  = 1'b1;
        raw_word = {OP_LW, in_rs1, in_rd, in_iv[15:0]};
      end
      STORE: begin
        code_ok  = 1'b1;
        raw_word = {OP_SW, in_rs1, in_rs2, in_iv[15:0]};
      end
      BRANCH: begin
        lut      = branch_op(in_i);
        code_ok  = lut[6];
        raw_word = {lut[5:0], in_rs1, in_rs2, in_iv[15:0]};
      end
      JUMP: begin
        code_ok  = 1'b1;
        raw_word = {(in_link ? OP_JAL : OP_J), in_iv[25:0]};
      end
      JUMP_REG: begin
        code_ok  = 1'b1;
        raw_word = {(in_link ? OP_JALR : OP_JR), in_rs1, 5'd0, 16'd0};
      end
      LHI: begin
        code_ok  = 1'b1;
        raw_word = {OP_LHI, in_rs1, in_rd, in_iv[15:0]};
      end
      default: begin
        code_ok  = 1'b0;
        raw_word = 32'd0;
      end
    endcase
  end

`ifdef DLX_ENC_RANGECHK_EN
  // Immediate must survive the core's sign/zero extension unchanged
  always_comb begin
    range_ok = 1'b1;
    case (in_kind)
      I_ALU: begin
        if (i_is_signed(in_i)) begin
          range_ok = (&in_iv[31:15]) || !(|in_iv[31:15]);
        end else begin
          range_ok = (in_iv[31:16] == 16'd0);
        end
      end
      LOAD, STORE, BRANCH: range_ok = (&in_iv[31:15]) || !(|in_iv[31:15]);
      JUMP:                range_ok = (&in_iv[31:25]) || !(|in_iv[31:25]);
      LHI:                 range_ok = (in_iv[31:16] == 16'd0);
      default:             range_ok = 1'b1;
    endcase
  end
`else
  logic unused_iv_hi;
  assign unused_iv_hi = ^in_iv[31:26];
  assign range_ok     = 1'b1;
`endif

  assign enc_ok   = code_ok && range_ok;
  assign enc_word = enc_ok ? raw_word : 32'd0;

  // Sequencing: start/drain FSM, address counter and first-error capture
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          addr_cnt_d = base_addr;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      ST_RUN: begin
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_count == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      addr_cnt_d = addr_cnt_q + ADDR_W'(ADDR_STEP);
      if (!enc_ok && !err_q) begin
        err_d      = 1'b1;
        err_addr_d = addr_cnt_q;
      end
    end
  end

  // Registered control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
    end
  end

  dlx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (out_valid && out_ready),
    .wdata   ({addr_cnt_q, enc_word}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_dlx_encoder.sv
// Directed bench for dlx_encoder: table of ops with hand-computed words,
// plus sequences for back-pressure, error capture and mid-program reset.
module tb_dlx_encoder;
  import dlx_pkg::*;

  typedef struct packed {
    op_kind_t    kind;
    logic        link;
    logic [4:0]  i;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] iv;
    logic        last;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  op_kind_t    in_kind;
  logic        in_link;
  logic [4:0]  in_i, in_rs1, in_rs2, in_rd;
  logic [31:0] in_iv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        done;
  logic        err;
  logic [31:0] err_addr;

  int checks;
  int failures;
  int done_cnt;
  logic [31:0] got_data [$];
  logic [31:0] got_addr [$];
  vec_t vec [19];

  dlx_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_kind   (in_kind),
    .in_link   (in_link),
    .in_i      (in_i),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_iv     (in_iv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .done      (done),
    .err       (err),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake and every done pulse
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_addr.push_back(out_addr);
    end
    if (done) done_cnt++;
  end

  function automatic vec_t mk(op_kind_t k, logic l, logic [4:0] i, logic [4:0] s1,
                              logic [4:0] s2, logic [4:0] d, logic [31:0] iv,
                              logic last, logic [31:0] exp);
    vec_t v;
    v.kind = k; v.link = l; v.i = i; v.rs1 = s1; v.rs2 = s2; v.rd = d;
    v.iv = iv; v.last = last; v.exp = exp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_kind  = vec[idx].kind;
    in_link  = vec[idx].link;
    in_i     = vec[idx].i;
    in_rs1   = vec[idx].rs1;
    in_rs2   = vec[idx].rs2;
    in_rd    = vec[idx].rd;
    in_iv    = vec[idx].iv;
    in_last  = vec[idx].last;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout vec %0d: in_ready stayed 0, required 1", idx);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic startProgram(input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: done never pulsed, required 1", name);
    end
  endtask

  task automatic checkProgram(input string name, input int first, input int n, input logic [31:0] b);
    checkOutput({name, "_count"}, 64'(got_data.size()), 64'(n));
    for (int k = 0; k < n && k < got_data.size(); k++) begin
      checkOutput($sformatf("%s_data%0d", name, k), 64'(got_data[k]), 64'(vec[first+k].exp));
      checkOutput($sformatf("%s_addr%0d", name, k), 64'(got_addr[k]), 64'(b + 32'(4*k)));
    end
  endtask

  initial begin
    int done_snap;
    checks = 0; failures = 0; done_cnt = 0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_last = 1'b0; in_kind = R_ALU; in_link = 1'b0;
    in_i = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_iv = '0;
    out_ready = 1'b1;

    // Program A, base 0x100
    vec[0]  = mk(R_ALU,    1'b0, 5'd1,  5'd1,  5'd2, 5'd3, 32'h0,        1'b0, 32'h00221820);
    vec[1]  = mk(I_ALU,    1'b0, 5'd1,  5'd1,  5'd0, 5'd5, 32'hFFFFFFFF, 1'b0, 32'h2025FFFF);
    vec[2]  = mk(JUMP,     1'b1, 5'd0,  5'd0,  5'd0, 5'd0, 32'h10,       1'b0, 32'h0C000010);
    vec[3]  = mk(LOAD,     1'b0, 5'd0,  5'd4,  5'd0, 5'd6, 32'hFFFFFFFC, 1'b0, 32'h8C86FFFC);
    vec[4]  = mk(BRANCH,   1'b0, 5'd17, 5'd3,  5'd0, 5'd0, 32'h20,       1'b0, 32'h14600020);
    vec[5]  = mk(R_ALU,    1'b0, 5'd14, 5'd7,  5'd8, 5'd9, 32'h0,        1'b0, 32'h00E84807);
    vec[6]  = mk(JUMP_REG, 1'b0, 5'd0,  5'd31, 5'd0, 5'd0, 32'h0,        1'b0, 32'h4BE00000);
    vec[7]  = mk(LHI,      1'b0, 5'd0,  5'd0,  5'd0, 5'd1, 32'h1234,     1'b0, 32'h3C011234);
    vec[8]  = mk(I_ALU,    1'b0, 5'd13, 5'd2,  5'd0, 5'd3, 32'h5,        1'b0, 32'h64430005);
    vec[9]  = mk(STORE,    1'b0, 5'd0,  5'd2,  5'd7, 5'd0, 32'h8,        1'b1, 32'hAC470008);
    // Program B, base 0: faults at 0x8 and 0xC
    vec[10] = mk(R_ALU,    1'b0, 5'd1,  5'd0,  5'd0, 5'd0, 32'h0,        1'b0, 32'h00000020);
    vec[11] = mk(I_ALU,    1'b0, 5'd2,  5'd0,  5'd0, 5'd0, 32'h0,        1'b0, 32'h28000000);
    vec[12] = mk(R_ALU,    1'b0, 5'd15, 5'd1,  5'd2, 5'd3, 32'h0,        1'b0, 32'h00000000);
    vec[13] = mk(BRANCH,   1'b0, 5'd3,  5'd1,  5'd2, 5'd0, 32'h4,        1'b0, 32'h00000000);
    vec[14] = mk(LOAD,     1'b0, 5'd0,  5'd0,  5'd0, 5'd0, 32'h0,        1'b1, 32'h8C000000);
    // Program C, base 0x40, back-pressure
    vec[15] = mk(LHI,      1'b0, 5'd0,  5'd0,  5'd0, 5'd2, 32'hAB,       1'b0, 32'h3C0200AB);
    vec[16] = mk(JUMP,     1'b0, 5'd0,  5'd0,  5'd0, 5'd0, 32'h100,      1'b0, 32'h08000100);
    vec[17] = mk(JUMP_REG, 1'b1, 5'd0,  5'd5,  5'd0, 5'd0, 32'h0,        1'b1, 32'h4CA00000);
    // Program D, base 0: out-of-range logical immediate
`ifdef DLX_ENC_RANGECHK_EN
    vec[18] = mk(I_ALU,    1'b0, 5'd3,  5'd1,  5'd0, 5'd2, 32'h00010000, 1'b1, 32'h00000000);
`else
    vec[18] = mk(I_ALU,    1'b0, 5'd3,  5'd1,  5'd0, 5'd2, 32'h00010000, 1'b1, 32'h30220000);
`endif

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data",  64'(out_data),  64'd0);
    checkOutput("rst_out_addr",  64'(out_addr),  64'd0);
    checkOutput("rst_done",      64'(done),      64'd0);
    checkOutput("rst_err",       64'(err),       64'd0);
    checkOutput("rst_err_addr",  64'(err_addr),  64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Program A: all kinds, with a start pulse that must be ignored mid-run
    $display("[TB] program A");
    got_data.delete(); got_addr.delete(); done_cnt = 0;
    startProgram(32'h100);
    for (int k = 0; k <= 9; k++) begin
      if (k == 5) startProgram(32'hDEAD0000);
      applyStimulus(k);
    end
    waitDone("a_done");
    repeat (3) @(negedge clk);
    checkOutput("a_done_once", 64'(done_cnt), 64'd1);
    checkOutput("a_in_ready",  64'(in_ready), 64'd0);
    checkOutput("a_err",       64'(err),      64'd0);
    checkProgram("a", 0, 10, 32'h100);

    // Program B: unencodable ops, first fault address is kept
    $display("[TB] program B");
    got_data.delete(); got_addr.delete();
    startProgram(32'h0);
    for (int k = 10; k <= 14; k++) begin
      applyStimulus(k);
      if (k == 12) begin
        @(negedge clk);
        checkOutput("b_err_first",      64'(err),      64'd1);
        checkOutput("b_err_addr_first", 64'(err_addr), 64'h8);
      end
    end
    waitDone("b_done");
    checkOutput("b_err_final",      64'(err),      64'd1);
    checkOutput("b_err_addr_final", 64'(err_addr), 64'h8);
    checkProgram("b", 10, 5, 32'h0);

    // Program C: consumer stalled, FIFO fills after two pushes
    $display("[TB] program C");
    got_data.delete(); got_addr.delete();
    out_ready = 1'b0;
    startProgram(32'h40);
    @(negedge clk);
    checkOutput("c_err_cleared", 64'(err), 64'd0);
    applyStimulus(15);
    applyStimulus(16);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("c_full_in_ready%0d", c), 64'(in_ready), 64'd0);
    end
    checkOutput("c_head_valid", 64'(out_valid), 64'd1);
    checkOutput("c_head_data",  64'(out_data),  64'(vec[15].exp));
    checkOutput("c_head_addr",  64'(out_addr),  64'h40);
    out_ready = 1'b1;
    applyStimulus(17);
    waitDone("c_done");
    checkProgram("c", 15, 3, 32'h40);

    // Program D: immediate range handling
    $display("[TB] program D");
    got_data.delete(); got_addr.delete();
    startProgram(32'h0);
    applyStimulus(18);
    waitDone("d_done");
    checkProgram("d", 18, 1, 32'h0);
`ifdef DLX_ENC_RANGECHK_EN
    checkOutput("d_err",      64'(err),      64'd1);
    checkOutput("d_err_addr", 64'(err_addr), 64'd0);
`else
    checkOutput("d_err",      64'(err),      64'd0);
`endif

    // Reset mid-program: FIFO flushed, no done pulse
    $display("[TB] mid-program reset");
    out_ready = 1'b0;
    startProgram(32'h200);
    applyStimulus(0);
    applyStimulus(1);
    done_snap = done_cnt;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("r_out_valid", 64'(out_valid), 64'd0);
    checkOutput("r_in_ready",  64'(in_ready),  64'd0);
    checkOutput("r_out_addr",  64'(out_addr),  64'd0);
    repeat (3) @(negedge clk);
    checkOutput("r_no_done", 64'(done_cnt), 64'(done_snap));
    got_data.delete(); got_addr.delete();
    out_ready = 1'b1;
    startProgram(32'h300);
    applyStimulus(9);
    waitDone("r_done");
    checkProgram("r", 9, 1, 32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
